// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI master (mode 0, MSB first) driving SD card pins.
// Two clients share the link with fixed priority: A (CPU port) over B (DMA).
//
// Optional feature macro: SD_SPI_XFERCNT_EN adds the xfer_cnt port and its counter.
//
// Parameters:
//   DIV       sdclk half-period in clk cycles (1..255)
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   a_start/a_din       client A request strobe and tx byte
//   a_done              client A completion strobe
//   b_start/b_din       client B request strobe and tx byte
//   b_done              client B completion strobe
//   dout                last received byte, valid from a done strobe until the next one
//   busy                transfer in progress
//   cs_we/cs_val        client A chip-select write (1 = selected)
//   sdclk/sdcs_n/sddo   SPI pins to the card
//   sddi                SPI data from the card
//   xfer_cnt            completed transfer count (SD_SPI_XFERCNT_EN only)
//
// state    | meaning
// ST_IDLE  | no transfer; grants A first, then B, loading the shifter
// ST_SHIFT | clocking out 8 bits, sdclk toggles every DIV cycles
module sd_spi_master #(
   parameter int unsigned DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_start,
   input  logic [7:0]  a_din,
   output logic        a_done,
   input  logic        b_start,
   input  logic [7:0]  b_din,
   output logic        b_done,
   output logic [7:0]  dout,
   output logic        busy,
   input  logic        cs_we,
   input  logic        cs_val,
   output logic        sdclk,
   output logic        sdcs_n,
   output logic        sddo,
   input  logic        sddi
`ifdef SD_SPI_XFERCNT_EN
   ,
   output logic [15:0] xfer_cnt
`endif
);

   localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t      state_q, state_d;
   logic        a_pend_q, a_pend_d;
   logic        b_pend_q, b_pend_d;
   logic [7:0]  a_hold_q, a_hold_d;
   logic [7:0]  b_hold_q, b_hold_d;
   logic        owner_q, owner_d;      // 0 = A, 1 = B
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  div_q, div_d;
   logic [2:0]  fall_q, fall_d;
   logic        sdclk_q, sdclk_d;
   logic [7:0]  dout_q, dout_d;
   logic        a_done_q, a_done_d;
   logic        b_done_q, b_done_d;
   logic        csn_q, csn_d;
   logic        cs_hold_q, cs_hold_d;
   logic        cs_hvld_q, cs_hvld_d;

   logic tick;
   logic fall_edge;
   logic last_fall;
   logic a_active;
   logic b_active;

   assign tick      = (div_q == 8'd0);
   assign fall_edge = (state_q == ST_SHIFT) && tick && sdclk_q;
   assign last_fall = fall_edge && (fall_q == 3'd7);
   assign a_active  = (state_q == ST_SHIFT) && !owner_q;
   assign b_active  = (state_q == ST_SHIFT) && owner_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (a_pend_q || b_pend_q) state_d = ST_SHIFT;
         ST_SHIFT: if (last_fall)            state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      a_pend_d  = a_pend_q;
      b_pend_d  = b_pend_q;
      a_hold_d  = a_hold_q;
      b_hold_d  = b_hold_q;
      owner_d   = owner_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      div_d     = div_q;
      fall_d    = fall_q;
      sdclk_d   = sdclk_q;
      dout_d    = dout_q;
      a_done_d  = 1'b0;
      b_done_d  = 1'b0;
      csn_d     = csn_q;
      cs_hold_d = cs_hold_q;
      cs_hvld_d = cs_hvld_q;

      // A start while that client is already queued or on the wire keeps the first byte.
      if (a_start && !a_pend_q && !a_active) begin
         a_pend_d = 1'b1;
         a_hold_d = a_din;
      end
      if (b_start && !b_pend_q && !b_active) begin
         b_pend_d = 1'b1;
         b_hold_d = b_din;
      end

      case (state_q)
         ST_IDLE: begin
            if (a_pend_q) begin
               a_pend_d = 1'b0;
               owner_d  = 1'b0;
               tx_d     = a_hold_q;
            end else if (b_pend_q) begin
               b_pend_d = 1'b0;
               owner_d  = 1'b1;
               tx_d     = b_hold_q;
            end
            div_d   = DIV_RELOAD;
            fall_d  = 3'd0;
            sdclk_d = 1'b0;
            if (cs_we) begin
               csn_d     = ~cs_val;
               cs_hvld_d = 1'b0;
            end else if (cs_hvld_q) begin
               csn_d     = ~cs_hold_q;
               cs_hvld_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               div_d   = DIV_RELOAD;
               sdclk_d = ~sdclk_q;
            end else begin
               div_d = div_q - 8'd1;
            end
            if (fall_edge) begin
               rx_d   = {rx_q[6:0], sddi};
               tx_d   = {tx_q[6:0], 1'b1};
               fall_d = fall_q + 3'd1;
            end
            if (last_fall) begin
               dout_d   = {rx_q[6:0], sddi};
               a_done_d = ~owner_q;
               b_done_d = owner_q;
            end
            // Chip-select writes during a transfer wait until it completes.
            if (cs_we) begin
               cs_hold_d = cs_val;
               cs_hvld_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_pend_q  <= 1'b0;
         b_pend_q  <= 1'b0;
         a_hold_q  <= 8'h00;
         b_hold_q  <= 8'h00;
         owner_q   <= 1'b0;
         tx_q      <= 8'hFF;
         rx_q      <= 8'hFF;
         div_q     <= 8'd0;
         fall_q    <= 3'd0;
         sdclk_q   <= 1'b0;
         dout_q    <= 8'hFF;
         a_done_q  <= 1'b0;
         b_done_q  <= 1'b0;
         csn_q     <= 1'b1;
         cs_hold_q <= 1'b0;
         cs_hvld_q <= 1'b0;
      end else begin
         a_pend_q  <= a_pend_d;
         b_pend_q  <= b_pend_d;
         a_hold_q  <= a_hold_d;
         b_hold_q  <= b_hold_d;
         owner_q   <= owner_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         div_q     <= div_d;
         fall_q    <= fall_d;
         sdclk_q   <= sdclk_d;
         dout_q    <= dout_d;
         a_done_q  <= a_done_d;
         b_done_q  <= b_done_d;
         csn_q     <= csn_d;
         cs_hold_q <= cs_hold_d;
         cs_hvld_q <= cs_hvld_d;
      end
   end

   // tx shifts in 1s, so its MSB is also the idle-high data line.
   assign sddo   = tx_q[7];
   assign sdclk  = sdclk_q;
   assign sdcs_n = csn_q;
   assign dout   = dout_q;
   assign a_done = a_done_q;
   assign b_done = b_done_q;
   assign busy   = (state_q == ST_SHIFT);

`ifdef SD_SPI_XFERCNT_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (a_done_d || b_done_d) xfer_cnt_d = xfer_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) xfer_cnt_q <= 16'd0;
      else     xfer_cnt_q <= xfer_cnt_d;
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// Testbench for sd_spi_master: card emulator, wire/done monitors and
// scenario tasks checked against expectations derived from the transfer rules.
module tb_sd_spi_master;

   localparam int DIV = 2;
   localparam int LAT = 1 + 16 * DIV;   // start-sampling edge to done, in clk edges

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_start = 1'b0;
   logic [7:0]  a_din = 8'h00;
   logic        a_done;
   logic        b_start = 1'b0;
   logic [7:0]  b_din = 8'h00;
   logic        b_done;
   logic [7:0]  dout;
   logic        busy;
   logic        cs_we = 1'b0;
   logic        cs_val = 1'b0;
   logic        sdclk;
   logic        sdcs_n;
   logic        sddo;
   logic        sddi;
`ifdef SD_SPI_XFERCNT_EN
   logic [15:0] xfer_cnt;
`endif

   int errors = 0;
   int checks = 0;

   sd_spi_master #(.DIV(DIV)) dut (
      .clk(clk), .rst(rst),
      .a_start(a_start), .a_din(a_din), .a_done(a_done),
      .b_start(b_start), .b_din(b_din), .b_done(b_done),
      .dout(dout), .busy(busy),
      .cs_we(cs_we), .cs_val(cs_val),
      .sdclk(sdclk), .sdcs_n(sdcs_n), .sddo(sddo), .sddi(sddi)
`ifdef SD_SPI_XFERCNT_EN
      , .xfer_cnt(xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Card emulator: byte k of emu_bytes is returned MSB first, one bit per sdclk fall.
   logic [7:0] emu_bytes[$];
   int         emu_fall = 0;
   logic [7:0] emu_cur;
   logic [2:0] emu_ph;
   int         emu_idx;

   always @(negedge sdclk or posedge rst) begin
      if (rst) emu_fall = ((emu_fall + 7) / 8) * 8;   // drop a partial byte
      else     emu_fall = emu_fall + 1;
   end

   assign emu_idx = emu_fall / 8;
   assign emu_ph  = 3'(emu_fall % 8);
   assign emu_cur = (emu_idx < emu_bytes.size()) ? emu_bytes[emu_idx] : 8'hFF;
   assign sddi    = emu_cur[3'd7 - emu_ph];

   // Wire monitor: card samples sddo on each sdclk rise.
   logic [7:0] wire_log[$];
   logic [7:0] wire_sr = 8'hFF;
   int         wire_cnt = 0;

   always @(posedge sdclk or posedge rst) begin
      if (rst) begin
         wire_cnt = 0;
      end else begin
         wire_sr  = {wire_sr[6:0], sddo};
         wire_cnt = wire_cnt + 1;
         if (wire_cnt == 8) begin
            wire_log.push_back(wire_sr);
            wire_cnt = 0;
         end
      end
   end

   // Done monitor: order of completions and the byte reported with each.
   bit         done_log[$];     // 0 = A, 1 = B
   logic [7:0] dout_log[$];
   int         a_cnt = 0;
   int         b_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (a_done === 1'b1) begin
         a_cnt = a_cnt + 1;
         done_log.push_back(1'b0);
         dout_log.push_back(dout);
      end
      if (b_done === 1'b1) begin
         b_cnt = b_cnt + 1;
         done_log.push_back(1'b1);
         dout_log.push_back(dout);
      end
   end

   task automatic pulse_start(input bit do_a, input bit do_b, input logic [7:0] da, input logic [7:0] db);
      @(negedge clk);
      a_start = do_a; a_din = da;
      b_start = do_b; b_din = db;
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic wait_done(input bit cl_b, input int maxc, output int lat, output bit got);
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= maxc && !got; k++) begin
         @(posedge clk);
         #1;
         if ((cl_b ? b_done : a_done) === 1'b1) begin
            got = 1'b1;
            lat = k;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sdclk !== 1'b0 || sdcs_n !== 1'b1 || sddo !== 1'b1 || busy !== 1'b0 ||
          a_done !== 1'b0 || b_done !== 1'b0)
         begin errors++; $display("FAIL reset_pins: got sdclk=%b sdcs_n=%b sddo=%b busy=%b a_done=%b b_done=%b, expected 0 1 1 0 0 0",
                                  sdclk, sdcs_n, sddo, busy, a_done, b_done); end
      checks++;
      if (dout !== 8'hFF) begin errors++; $display("FAIL reset_dout: got %h expected ff", dout); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat; bit got; int wb;
      wb = wire_log.size();
      emu_bytes.push_back(8'h3C);
      pulse_start(1'b1, 1'b0, 8'hA5, 8'h00);
      wait_done(1'b0, 200, lat, got);
      checks++;
      if (!got) begin errors++; $display("FAIL basic_done: got no a_done, expected one"); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
      checks++;
      if (dout !== 8'h3C) begin errors++; $display("FAIL basic_dout: got %h expected 3c", dout); end
      @(posedge clk); #1;
      checks++;
      if (a_done !== 1'b0 || busy !== 1'b0 || sddo !== 1'b1)
         begin errors++; $display("FAIL basic_after: got a_done=%b busy=%b sddo=%b expected 0 0 1", a_done, busy, sddo); end
      checks++;
      if (wire_log.size() != wb + 1 || wire_log[wb] !== 8'hA5)
         begin errors++; $display("FAIL basic_wire: got %0d bytes first=%h expected 1 byte a5", wire_log.size() - wb, wire_log[wb]); end
   endtask

   task automatic test_simultaneous();
      int lat; bit got; int db; int wb;
      logic [7:0] txa, txb, rxa, rxb;
      txa = 8'h11; txb = 8'h22;
      rxa = 8'($urandom); rxb = 8'($urandom);
      db = done_log.size(); wb = wire_log.size();
      emu_bytes.push_back(rxa);
      emu_bytes.push_back(rxb);
      pulse_start(1'b1, 1'b1, txa, txb);
      wait_done(1'b1, 400, lat, got);
      @(negedge clk);
      checks++;
      if (!got || lat != 2 * LAT) begin errors++; $display("FAIL simul_b_latency: got done=%b lat=%0d expected 1 %0d", got, lat, 2 * LAT); end
      checks++;
      if (done_log.size() != db + 2 || done_log[db] !== 1'b0 || done_log[db + 1] !== 1'b1)
         begin errors++; $display("FAIL simul_order: got %0d dones expected A then B", done_log.size() - db); end
      checks++;
      if (dout_log.size() != db + 2 || dout_log[db] !== rxa || dout_log[db + 1] !== rxb)
         begin errors++; $display("FAIL simul_dout: got %h %h expected %h %h", dout_log[db], dout_log[db + 1], rxa, rxb); end
      checks++;
      if (wire_log.size() != wb + 2 || wire_log[wb] !== txa || wire_log[wb + 1] !== txb)
         begin errors++; $display("FAIL simul_wire: got %h %h expected %h %h", wire_log[wb], wire_log[wb + 1], txa, txb); end
   endtask

   task automatic test_cs_hold();
      int lat; bit got; int bad; bit busy_seen;
      @(negedge clk); cs_we = 1'b1; cs_val = 1'b1;
      @(negedge clk); cs_we = 1'b0;
      checks++;
      if (sdcs_n !== 1'b0) begin errors++; $display("FAIL cs_select_idle: got %b expected 0", sdcs_n); end
      emu_bytes.push_back(8'($urandom));
      pulse_start(1'b1, 1'b0, 8'($urandom), 8'h00);
      repeat (8) @(negedge clk);
      busy_seen = busy;
      cs_we = 1'b1; cs_val = 1'b0;
      @(negedge clk); cs_we = 1'b0;
      checks++;
      if (busy_seen !== 1'b1) begin errors++; $display("FAIL cs_busy_mid: got %b expected 1", busy_seen); end
      bad = 0; got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(posedge clk); #1;
         if (sdcs_n !== 1'b0) bad++;
         if (a_done === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || bad != 0) begin errors++; $display("FAIL cs_held: got done=%b early_deselect_cycles=%0d expected 1 0", got, bad); end
      @(posedge clk); #1;
      checks++;
      if (sdcs_n !== 1'b1) begin errors++; $display("FAIL cs_apply_after_done: got %b expected 1", sdcs_n); end
      lat = 0;
   endtask

   task automatic test_reset_mid();
      int lat; bit got; int falls; logic prev; int a0; int wb;
      logic [7:0] tx, rx;
      @(negedge clk); cs_we = 1'b1; cs_val = 1'b1;
      @(negedge clk); cs_we = 1'b0;
      emu_bytes.push_back(8'($urandom));
      pulse_start(1'b1, 1'b0, 8'($urandom), 8'h00);
      a0 = a_cnt;
      falls = 0; prev = sdclk;
      for (int k = 0; k < 200 && falls < 4; k++) begin
         @(posedge clk); #1;
         if (prev === 1'b1 && sdclk === 1'b0) falls++;
         prev = sdclk;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (falls != 4 || sdclk !== 1'b0 || sdcs_n !== 1'b1 || busy !== 1'b0 || sddo !== 1'b1)
         begin errors++; $display("FAIL rstmid_pins: got falls=%0d sdclk=%b sdcs_n=%b busy=%b sddo=%b expected 4 0 1 0 1",
                                  falls, sdclk, sdcs_n, busy, sddo); end
      @(negedge clk); rst = 1'b0;
      repeat (60) @(negedge clk);
      checks++;
      if (a_cnt != a0) begin errors++; $display("FAIL rstmid_no_done: got %0d dones expected 0", a_cnt - a0); end
      tx = 8'($urandom); rx = 8'($urandom);
      wb = wire_log.size();
      emu_bytes.push_back(rx);
      pulse_start(1'b1, 1'b0, tx, 8'h00);
      wait_done(1'b0, 200, lat, got);
      checks++;
      if (!got || lat != LAT || dout !== rx)
         begin errors++; $display("FAIL rstmid_restart: got done=%b lat=%0d dout=%h expected 1 %0d %h", got, lat, dout, LAT, rx); end
      @(negedge clk);
      checks++;
      if (wire_log.size() != wb + 1 || wire_log[wb] !== tx)
         begin errors++; $display("FAIL rstmid_wire: got %h expected %h", wire_log[wb], tx); end
   endtask

   task automatic test_repeat_start();
      int lat; bit got; int a0; int wb;
      logic [7:0] tx, rx;
      tx = 8'($urandom); rx = 8'($urandom);
      a0 = a_cnt; wb = wire_log.size();
      emu_bytes.push_back(rx);
      pulse_start(1'b1, 1'b0, tx, 8'h00);
      pulse_start(1'b1, 1'b0, ~tx, 8'h00);   // arrives in the grant cycle
      repeat (5) @(negedge clk);
      pulse_start(1'b1, 1'b0, tx ^ 8'h5A, 8'h00);
      wait_done(1'b0, 200, lat, got);
      repeat (80) @(negedge clk);
      checks++;
      if (a_cnt - a0 != 1) begin errors++; $display("FAIL repeat_done_count: got %0d expected 1", a_cnt - a0); end
      checks++;
      if (wire_log.size() != wb + 1 || wire_log[wb] !== tx)
         begin errors++; $display("FAIL repeat_wire: got %0d bytes first=%h expected 1 byte %h", wire_log.size() - wb, wire_log[wb], tx); end
      checks++;
      if (!got || busy !== 1'b0 || dout !== rx) begin errors++; $display("FAIL repeat_dout: got %h expected %h", dout, rx); end
   endtask

   task automatic test_random();
      int lat; bit got; int wb; bit cl;
      logic [7:0] tx, rx;
      for (int i = 0; i < 12; i++) begin
         cl = 1'($urandom_range(0, 1));
         tx = 8'($urandom); rx = 8'($urandom);
         wb = wire_log.size();
         emu_bytes.push_back(rx);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         pulse_start(!cl, cl, tx, tx);
         wait_done(cl, 200, lat, got);
         checks++;
         if (!got || lat != LAT || dout !== rx)
            begin errors++; $display("FAIL random_xfer[%0d]: got done=%b lat=%0d dout=%h expected 1 %0d %h", i, got, lat, dout, LAT, rx); end
         @(negedge clk);
         checks++;
         if (wire_log.size() != wb + 1 || wire_log[wb] !== tx)
            begin errors++; $display("FAIL random_wire[%0d]: got %h expected %h", i, wire_log[wb], tx); end
      end
   endtask

`ifdef SD_SPI_XFERCNT_EN
   task automatic test_xfercnt();
      int lat; bit got; int missing;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      checks++;
      if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL xfercnt_reset: got %0d expected 0", xfer_cnt); end
      missing = 0;
      for (int i = 0; i < 300; i++) begin
         emu_bytes.push_back(8'($urandom));
         pulse_start(1'b1, 1'b0, 8'($urandom), 8'h00);
         wait_done(1'b0, 200, lat, got);
         if (!got) missing++;
      end
      @(negedge clk);
      checks++;
      if (missing != 0 || xfer_cnt !== 16'd300)
         begin errors++; $display("FAIL xfercnt_300: got %0d (missing %0d) expected 300", xfer_cnt, missing); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_simultaneous();
      test_cs_hold();
      test_reset_mid();
      test_repeat_start();
      test_random();
`ifdef SD_SPI_XFERCNT_EN
      test_xfercnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
